// File: rtl/mem_access.sv
// Memory-access stage: alignment check, single-outstanding data-bus request,
// load byte alignment and store lane masks for the RV64 pipeline.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [2:0]  ex_mem,
  input  logic        ex_store,
  input  logic [1:0]  ex_store_size,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  input  logic [63:0] ex_rd_data,
  input  logic        ex_rd_ena,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic [7:0]  dmem_wmask,
  input  logic        dmem_rsp_valid,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic [63:0] mem_r_data,
  output logic [2:0]  mem,
  output logic        rd_data_mem_ena,
  output logic [63:0] rd_data_exe,
  output logic        rd_data_exe_ena,
  output logic        misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_t;

  state_t      state_q, state_d;
  logic        load_q, load_d;
  logic [2:0]  off_q, off_d;
  logic        req_valid_q, req_valid_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic        wb_valid_q, wb_valid_d;
  logic [63:0] mrd_q, mrd_d;
  logic [2:0]  mem_q, mem_d;
  logic        mem_ena_q, mem_ena_d;
  logic [63:0] exe_q, exe_d;
  logic        exe_ena_q, exe_ena_d;
  logic        mis_q, mis_d;

  logic        is_load, is_mem, aligned;
  logic [1:0]  lsz, sz;
  logic [7:0]  base_mask;
  logic [63:0] rep;

  // Access size as log2(bytes); stores take their size from ex_store_size
  always_comb begin
    lsz = 2'd0;
    unique case (1'b1)
      (ex_mem == 3'd2) || (ex_mem == 3'd5): lsz = 2'd1;
      (ex_mem == 3'd3) || (ex_mem == 3'd6): lsz = 2'd2;
      (ex_mem == 3'd7):                     lsz = 2'd3;
      default:                              lsz = 2'd0;
    endcase
    is_load = !ex_store && (ex_mem != 3'd0);
    is_mem  = ex_store || is_load;
    sz      = ex_store ? ex_store_size : lsz;
    aligned   = 1'b1;
    base_mask = 8'hFF;
    rep       = ex_wdata;
    unique case (sz)
      2'd0: begin
        base_mask = 8'h01;
        rep       = {8{ex_wdata[7:0]}};
      end
      2'd1: begin
        aligned   = !ex_addr[0];
        base_mask = 8'h03;
        rep       = {4{ex_wdata[15:0]}};
      end
      2'd2: begin
        aligned   = (ex_addr[1:0] == 2'd0);
        base_mask = 8'h0F;
        rep       = {2{ex_wdata[31:0]}};
      end
      default: begin
        aligned   = (ex_addr[2:0] == 3'd0);
        base_mask = 8'hFF;
        rep       = ex_wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    off_d       = off_q;
    req_valid_d = req_valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    mrd_d       = mrd_q;
    mem_d       = mem_q;
    exe_d       = exe_q;
    wb_valid_d  = 1'b0;
    mem_ena_d   = 1'b0;
    exe_ena_d   = 1'b0;
    mis_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          load_d  = is_load;
          off_d   = ex_addr[2:0];
          we_d    = ex_store;
          addr_d  = {ex_addr[63:3], 3'b000};
          wdata_d = ex_store ? rep : 64'd0;
          wmask_d = ex_store ? (base_mask << ex_addr[2:0]) : 8'd0;
          mem_d   = ex_store ? 3'd0 : ex_mem;
          exe_d   = ex_rd_data;
          if (!is_mem) begin
            state_d    = RESP;
            wb_valid_d = 1'b1;
            exe_ena_d  = ex_rd_ena;
          end else if (!aligned) begin
            state_d    = RESP;
            wb_valid_d = 1'b1;
            mis_d      = 1'b1;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem_rsp_valid) begin
          if (load_q) mrd_d = dmem_rdata >> {off_q, 3'b000};
          state_d    = RESP;
          wb_valid_d = 1'b1;
          mem_ena_d  = load_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      load_q      <= 1'b0;
      off_q       <= 3'd0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      wmask_q     <= 8'd0;
      wb_valid_q  <= 1'b0;
      mrd_q       <= 64'd0;
      mem_q       <= 3'd0;
      mem_ena_q   <= 1'b0;
      exe_q       <= 64'd0;
      exe_ena_q   <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      off_q       <= off_d;
      req_valid_q <= req_valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      wb_valid_q  <= wb_valid_d;
      mrd_q       <= mrd_d;
      mem_q       <= mem_d;
      mem_ena_q   <= mem_ena_d;
      exe_q       <= exe_d;
      exe_ena_q   <= exe_ena_d;
      mis_q       <= mis_d;
    end
  end

  assign ex_ready        = (state_q == IDLE) && rst;
  assign dmem_req_valid  = req_valid_q;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign dmem_wmask      = wmask_q;
  assign wb_valid        = wb_valid_q;
  assign mem_r_data      = mrd_q;
  assign mem             = mem_q;
  assign rd_data_mem_ena = mem_ena_q;
  assign rd_data_exe     = exe_q;
  assign rd_data_exe_ena = exe_ena_q;
  assign misalign_err    = mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases then random ops checked against
// a byte-level model of alignment, lanes and load shifting.
module tb_mem_access;

  logic        clk, rst;
  logic        ex_valid, ex_ready;
  logic [2:0]  ex_mem;
  logic        ex_store;
  logic [1:0]  ex_store_size;
  logic [63:0] ex_addr, ex_wdata, ex_rd_data;
  logic        ex_rd_ena;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_wmask;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rdata;
  logic        wb_valid;
  logic [63:0] mem_r_data;
  logic [2:0]  mem;
  logic        rd_data_mem_ena;
  logic [63:0] rd_data_exe;
  logic        rd_data_exe_ena;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_mrd = 64'd0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem(ex_mem), .ex_store(ex_store),
    .ex_store_size(ex_store_size), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd_data(ex_rd_data),
    .ex_rd_ena(ex_rd_ena),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_rsp_valid(dmem_rsp_valid),
    .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .mem_r_data(mem_r_data),
    .mem(mem), .rd_data_mem_ena(rd_data_mem_ena),
    .rd_data_exe(rd_data_exe),
    .rd_data_exe_ena(rd_data_exe_ena),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic st, input logic [2:0] code,
                                input logic [1:0] ssz);
    if (st) return 1 << ssz;
    case (code)
      3'd2, 3'd5: return 2;
      3'd3, 3'd6: return 4;
      3'd7:       return 8;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [63:0] lanes(input logic [63:0] w, input int nb);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = w[(i % nb)*8 +: 8];
    return r;
  endfunction

  // One full op: drive, follow the bus handshake, check the writeback strobe
  task automatic do_op(input logic st, input logic [2:0] code,
                       input logic [1:0] ssz, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] rdd,
                       input logic rde, input int rdly, input int sdly,
                       input logic [63:0] rdata);
    int nb;
    logic ld, memop, mis;
    logic [7:0] xmask;
    nb    = nbytes(st, code, ssz);
    ld    = !st && code != 3'd0;
    memop = st || ld;
    mis   = memop && (a % nb) != 0;
    xmask = 8'(((1 << nb) - 1) << (a % 8));
    chk("ex_ready_idle", 64'(ex_ready), 64'd1);
    ex_valid = 1'b1; ex_store = st; ex_mem = code;
    ex_store_size = ssz; ex_addr = a; ex_wdata = wd;
    ex_rd_data = rdd; ex_rd_ena = rde;
    @(negedge clk);
    ex_valid = 1'b0;
    if (memop && !mis) begin
      for (int i = 0; i <= rdly; i++) begin
        chk("req_valid", 64'(dmem_req_valid), 64'd1);
        chk("ex_ready_busy", 64'(ex_ready), 64'd0);
        chk("req_we", 64'(dmem_we), 64'(st));
        chk("req_addr", dmem_addr, {a[63:3], 3'b000});
        chk("req_wmask", 64'(dmem_wmask), st ? 64'(xmask) : 64'd0);
        if (st) chk("req_wdata", dmem_wdata, lanes(wd, nb));
        dmem_rsp_valid = (i < rdly) ? 1'($urandom % 2) : 1'b0;
        dmem_rdata = {$urandom, $urandom};
        if (i == rdly) dmem_req_ready = 1'b1;
        @(negedge clk);
      end
      dmem_req_ready = 1'b0;
      chk("req_dropped", 64'(dmem_req_valid), 64'd0);
      for (int i = 0; i < sdly; i++) begin
        chk("no_early_wb", 64'(wb_valid), 64'd0);
        @(negedge clk);
      end
      dmem_rsp_valid = 1'b1;
      dmem_rdata = rdata;
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      if (ld) last_mrd = rdata >> (8 * (a % 8));
    end else begin
      chk("no_req", 64'(dmem_req_valid), 64'd0);
    end
    chk("wb_valid", 64'(wb_valid), 64'd1);
    chk("misalign", 64'(misalign_err), 64'(mis));
    chk("mem_ena", 64'(rd_data_mem_ena), 64'(ld && !mis));
    chk("exe_ena", 64'(rd_data_exe_ena), 64'(!memop && rde));
    chk("rd_data_exe", rd_data_exe, rdd);
    chk("mem_r_data", mem_r_data, last_mrd);
    if (!(ld && mis)) chk("mem_code", 64'(mem), ld ? 64'(code) : 64'd0);
    @(negedge clk);
    chk("wb_pulse", 64'(wb_valid), 64'd0);
    chk("ena_low", 64'({rd_data_mem_ena, rd_data_exe_ena, misalign_err}),
        64'd0);
  endtask

  initial begin
    logic st, rde;
    logic [2:0] code;
    logic [1:0] ssz;
    logic [63:0] a;
    int kind;
    rst = 1'b0; ex_valid = 1'b0; ex_mem = 3'd0; ex_store = 1'b0;
    ex_store_size = 2'd0; ex_addr = '0; ex_wdata = '0;
    ex_rd_data = '0; ex_rd_ena = 1'b0; dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0000_FFFF;
    #12;
    chk("rst_ex_ready", 64'(ex_ready), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_data", dmem_addr | dmem_wdata | mem_r_data | rd_data_exe, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("stale_ack", 64'(wb_valid), 64'd0);
    dmem_rsp_valid = 1'b0;

    do_op(0, 3'd0, 2'd0, 64'h40, 64'd0, 64'h1234, 1, 0, 0, 64'd0);
    do_op(0, 3'd1, 2'd0, 64'h1005, 64'd0, 64'h1, 1, 0, 0,
          64'h0000_AA00_0000_0000);
    chk("lb_byte", 64'(mem_r_data[7:0]), 64'hAA);
    do_op(1, 3'd0, 2'd1, 64'h2006, 64'hBEEF, 64'h2, 1, 3, 0, 64'd0);
    do_op(0, 3'd3, 2'd0, 64'h3002, 64'd0, 64'h3, 1, 0, 0, 64'd0);

    // Reset while the load waits for its response
    ex_valid = 1'b1; ex_store = 1'b0; ex_mem = 3'd7; ex_addr = 64'h88;
    @(negedge clk);
    ex_valid = 1'b0; dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_req", 64'(dmem_req_valid), 64'd0);
    chk("midrst_ready", 64'(ex_ready), 64'd0);
    chk("midrst_data", dmem_addr | mem_r_data | rd_data_exe, 64'd0);
    last_mrd = 64'd0;
    @(negedge clk);
    rst = 1'b1; dmem_rsp_valid = 1'b1; dmem_rdata = 64'hFFFF;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    chk("midrst_no_wb", 64'(wb_valid), 64'd0);
    @(negedge clk);
    chk("midrst_no_wb2", 64'(wb_valid), 64'd0);
    do_op(0, 3'd7, 2'd0, 64'h90, 64'd0, 64'h5, 0, 1, 2,
          64'h0123_4567_89AB_CDEF);

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 2);
      st   = (kind == 2);
      code = (kind == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      ssz  = 2'($urandom);
      a    = {$urandom, $urandom};
      if ($urandom % 2) a[2:0] = 3'd0;
      rde  = 1'($urandom);
      do_op(st, code, ssz, a, {$urandom, $urandom}, {$urandom, $urandom},
            rde, $urandom_range(0, 3), $urandom_range(0, 3),
            {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
